// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: turns two raw, bouncy, asynchronous set/clear request
// lines into clean, registered, fixed-width s/r pulses for an SR flip-flop.
// Each line is synchronised, debounced and rising-edge detected; a small FSM
// launches one pulse at a time and flags set/clear edges that coincide.
module sr_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int PULSE_CYCLES    = 1,
    parameter int PW              = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic clr_raw,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]    PCNT_LAST = PW'(PULSE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SETP = 2'd1;
    localparam logic [1:0] ST_CLRP = 2'd2;

    // Channel 0 carries the set request, channel 1 the clear request.
    logic [1:0] w_raw;
    logic [1:0] w_req;

    assign w_raw = {clr_raw, set_raw};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic             r_sync1;
        logic             r_sync2;
        logic             r_deb;
        logic             r_deb_d;
        logic [CNT_W-1:0] r_cnt;

        // Two-flop synchroniser for the asynchronous raw line.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_deb <= 1'b0;
                r_cnt <= '0;
            end else if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        // One-cycle history of the debounced level for rising-edge detection.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_deb_d <= 1'b0;
            end else begin
                r_deb_d <= r_deb;
            end
        end

        // Only the rising edge of the debounced level is a request.
        assign w_req[g] = r_deb & ~r_deb_d;
    end

    logic [1:0]    r_state;
    logic [PW-1:0] r_pcnt;
    logic          r_s;
    logic          r_r;
    logic          r_busy;
    logic          r_conflict;

    // Pulse FSM: one pulse at a time; requests during a pulse are dropped,
    // coincident set/clear edges in IDLE raise a one-cycle conflict instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pcnt     <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req[0] && w_req[1]) begin
                        r_conflict <= 1'b1;
                    end else if (w_req[0]) begin
                        r_state <= ST_SETP;
                        r_s     <= 1'b1;
                        r_busy  <= 1'b1;
                        r_pcnt  <= '0;
                    end else if (w_req[1]) begin
                        r_state <= ST_CLRP;
                        r_r     <= 1'b1;
                        r_busy  <= 1'b1;
                        r_pcnt  <= '0;
                    end
                end
                ST_SETP, ST_CLRP: begin
                    if (r_pcnt == PCNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_pcnt  <= '0;
                    end else begin
                        r_pcnt <= r_pcnt + PW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_pcnt  <= '0;
                end
            endcase
        end
    end

    assign s        = r_s;
    assign r        = r_r;
    assign busy     = r_busy;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// tb_sr_cmd_conditioner: directed scenarios plus random bouncy stimulus,
// compared every cycle against a history-window reference model; a small
// SR flip-flop driven by s/r must track the model's expected state.
module tb_sr_cmd_conditioner;

    localparam int D  = 4;
    localparam int P  = 2;
    localparam int HN = 8192;

    logic clk;
    logic rst;
    logic set_raw;
    logic clr_raw;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    logic q;
    logic qbar;

    int n_checks;
    int n_errors;

    sr_cmd_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3),
        .PULSE_CYCLES(P),
        .PW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .set_raw(set_raw),
        .clr_raw(clr_raw),
        .s(s),
        .r(r),
        .busy(busy),
        .conflict(conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream SR flip-flop fed by the conditioner.
    always @(posedge clk or negedge rst) begin
        if (!rst)   q <= 1'b0;
        else if (s) q <= 1'b1;
        else if (r) q <= 1'b0;
    end
    assign qbar = ~q;

    // ---------------- reference model ----------------
    // Per channel: raw samples taken at each edge since reset, and the
    // synchronised value seen by the debouncer at each edge.
    bit m_samp [0:1][0:HN-1];
    bit m_seen [0:1][0:HN-1];
    bit m_deb  [0:1];
    bit m_rose [0:1];
    int m_last [0:1];
    int m_n;
    int m_left;
    int m_kind;
    bit m_conf;
    bit m_q;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_left = 0;
        m_kind = 0;
        m_conf = 1'b0;
        m_q = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_deb[c]  = 1'b0;
            m_rose[c] = 1'b0;
            m_last[c] = -1;
        end
    endtask

    function automatic bit exp_s();
        return (m_left > 0) && (m_kind == 0);
    endfunction

    function automatic bit exp_r();
        return (m_left > 0) && (m_kind == 1);
    endfunction

    // Advance the model by one rising clock edge with the current raw inputs.
    task automatic model_edge();
        bit req [0:1];
        bit raw [0:1];
        bit sv;
        bit flip;
        raw[0] = set_raw;
        raw[1] = clr_raw;
        // A request seen at this edge is a debounced rise that happened at the previous edge.
        for (int c = 0; c < 2; c++) req[c] = m_rose[c];
        for (int c = 0; c < 2; c++) begin
            // The debouncer sees the raw value sampled two edges ago.
            sv = (m_n >= 2) ? m_samp[c][m_n-2] : 1'b0;
            m_seen[c][m_n] = sv;
            // Level flips once the last D samples since the previous flip all disagree.
            flip = (m_n - m_last[c] >= D);
            if (flip)
                for (int k = 0; k < D; k++)
                    if (m_seen[c][m_n-k] == m_deb[c]) flip = 1'b0;
            m_rose[c] = flip && !m_deb[c];
            if (flip) begin
                m_deb[c]  = !m_deb[c];
                m_last[c] = m_n;
            end
            m_samp[c][m_n] = raw[c];
        end
        // Flip-flop reacts to the pulse levels present before this edge.
        if (exp_s())      m_q = 1'b1;
        else if (exp_r()) m_q = 1'b0;
        m_conf = 1'b0;
        if (m_left > 0)               m_left--;
        else if (req[0] && req[1])    m_conf = 1'b1;
        else if (req[0]) begin m_left = P; m_kind = 0; end
        else if (req[1]) begin m_left = P; m_kind = 1; end
        m_n++;
    endtask

    task automatic check_all();
        chk("s", s, exp_s());
        chk("r", r, exp_r());
        chk("busy", busy, m_left > 0);
        chk("conflict", conflict, m_conf);
        chk("s_and_r", s & r, 0);
        chk("q", q, m_q);
        chk("qbar", qbar, !m_q);
    endtask

    // Drive inputs at the falling edge, advance one clock, check at the next falling edge.
    task automatic cyc(input bit sr, input bit cr);
        set_raw = sr;
        clr_raw = cr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse in the middle of the low clock phase.
    task automatic mid_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    initial begin
        int first;
        int s_hi;
        int r_hi;
        int busy_hi;
        int conf_hi;
        int pulses;
        bit prev_s;
        int hold_s;
        int hold_c;
        bit lvl_s;
        bit lvl_c;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        set_raw = 1'b1;
        clr_raw = 1'b0;
        model_reset();

        // Held reset with a raw request active: everything stays quiet.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_all();
        end
        set_raw = 1'b0;
        rst = 1'b1;
        idle(8);

        // Clean set request held for 12 cycles.
        first = -1; s_hi = 0; r_hi = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0);
            if (s && first < 0) first = i;
            s_hi += int'(s);
            r_hi += int'(r);
        end
        chk("set_first_edge", first, 6);
        chk("set_width", s_hi, P);
        chk("set_r_quiet", r_hi, 0);
        s_hi = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0);
            s_hi += int'(s) + int'(r);
        end
        chk("release_quiet", s_hi, 0);

        // Short glitch is rejected.
        busy_hi = 0;
        for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0); busy_hi += int'(busy); end
        for (int i = 0; i < 10; i++) begin cyc(1'b0, 1'b0); busy_hi += int'(busy); end
        chk("glitch_busy", busy_hi, 0);

        // Held level with a one-cycle dropout gives exactly one pulse.
        pulses = 0; prev_s = 1'b0;
        for (int i = 0; i < 36; i++) begin
            if (i < 6)       cyc(1'b1, 1'b0);
            else if (i == 6) cyc(1'b0, 1'b0);
            else if (i < 17) cyc(1'b1, 1'b0);
            else             cyc(1'b0, 1'b0);
            if (s && !prev_s) pulses++;
            prev_s = s;
        end
        chk("dropout_pulses", pulses, 1);

        // Simultaneous set and clear.
        first = -1; conf_hi = 0; s_hi = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1);
            if (conflict && first < 0) first = i;
            conf_hi += int'(conflict);
            s_hi += int'(s) + int'(r);
        end
        chk("conflict_edge", first, 6);
        chk("conflict_width", conf_hi, 1);
        chk("conflict_no_pulse", s_hi, 0);
        idle(12);

        // Clear arrives one cycle after set: dropped while busy.
        s_hi = 0; r_hi = 0; conf_hi = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, i >= 1);
            s_hi += int'(s);
            r_hi += int'(r);
            conf_hi += int'(conflict);
        end
        chk("overlap_s", s_hi, P);
        chk("overlap_r", r_hi, 0);
        chk("overlap_conflict", conf_hi, 0);
        idle(12);

        // Reset in the middle of a pulse, request still held afterwards.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
        chk("pre_reset_s", s, 1);
        mid_reset();
        chk("reset_drops_s", s, 0);
        first = -1; s_hi = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 1'b0);
            if (s && first < 0) first = i;
            s_hi += int'(s);
        end
        chk("rerun_first_edge", first, 6);
        chk("rerun_width", s_hi, P);
        idle(12);

        // Random bouncy stimulus with occasional asynchronous resets.
        hold_s = 0; hold_c = 0; lvl_s = 1'b0; lvl_c = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if (hold_s == 0) begin lvl_s = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 8); end
            if (hold_c == 0) begin lvl_c = 1'($urandom_range(0, 1)); hold_c = $urandom_range(1, 8); end
            hold_s--;
            hold_c--;
            cyc(lvl_s, lvl_c);
            if ($urandom_range(0, 299) == 0) mid_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
